// File: rtl/arb_mux_pkg.sv
// Shared types for the arbitrated output multiplexer.
package arb_mux_pkg;

  // Arbitration state: free round-robin, or grant held for an open packet.
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux.sv
// One-hot select multiplexer: sel must be one-hot or zero; zero selects all-zero.
module mux #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  // AND-OR reduction of the selected lane.
  always_comb begin
    dout = '0;
    for (int unsigned j = 0; j < N; j++) begin
      dout = dout | (din[j] & {W{sel[j]}});
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant of the first requester at or after ptr.
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] rot_req;
  logic [N-1:0]   rot_gnt;
  logic [2*N-1:0] dbl_gnt;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    dbl_req = {req, req};
    rot_req = dbl_req >> ptr;
    rot_gnt = rot_req[N-1:0] & (~rot_req[N-1:0] + N'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    gnt     = dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/arb_mux.sv
// Arbitrated N-to-1 channel multiplexer with a single registered output stage.
// PKT=1 holds the grant on one channel from its first beat until its last beat.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 32,
  parameter int unsigned PKT = 0
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [N-1:0]          i_valid,
  input  logic [N-1:0][W-1:0]   i_data,
  input  logic [N-1:0]          i_last,
  output logic [N-1:0]          o_ready,
  output logic                  o_valid,
  output logic [W-1:0]          o_data,
  output logic                  o_last,
  output logic [$clog2(N)-1:0]  o_idx,
  input  logic                  i_ready
);

  localparam int unsigned IW = $clog2(N);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       lock_idx_q, lock_idx_d;
  logic [IW-1:0]       acc_idx;
  logic [IW-1:0]       next_ptr;
  logic [N-1:0]        arb_gnt;
  logic [N-1:0]        gnt;
  logic                locked;
  logic                load_en;
  logic                accept;
  logic [N-1:0][W:0]   mux_in;
  logic [W:0]          mux_out;
  logic [W-1:0]        sel_data;
  logic                sel_last;

  rr_arb #(
    .N  (N),
    .IW (IW)
  ) u_rr_arb (
    .req (i_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Pack last marker above data so one mux carries the whole beat.
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      mux_in[j] = {i_last[j], i_data[j]};
    end
  end

  mux #(
    .N (N),
    .W (W + 1)
  ) u_mux (
    .sel  (gnt),
    .din  (mux_in),
    .dout (mux_out)
  );

  assign sel_last = mux_out[W];
  assign sel_data = mux_out[W-1:0];

  // Grant: round-robin unless a packet holds the channel; locked idle channel blocks others.
  always_comb begin
    locked  = (PKT != 0) && (state_q == ST_LOCKED);
    gnt     = arb_gnt;
    if (locked) begin
      gnt = i_valid & (N'(1) << lock_idx_q);
    end
    load_en = !o_valid || i_ready;
    o_ready = gnt & {N{load_en}};
    accept  = |(i_valid & o_ready);
  end

  // Binary index of the granted channel and the round-robin successor.
  always_comb begin
    acc_idx = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (gnt[j]) begin
        acc_idx = IW'(j);
      end
    end
    next_ptr = (acc_idx == IW'(N - 1)) ? '0 : acc_idx + IW'(1);
  end

  // Next-state: pointer advance and packet lock tracking.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      if (PKT == 0) begin
        ptr_d = next_ptr;
      end else if (sel_last) begin
        state_d = ST_ARB;
        ptr_d   = next_ptr;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = acc_idx;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Output stage: loads the accepted beat; empties when nothing is accepted; holds under backpressure.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_idx   <= '0;
    end else if (load_en) begin
      o_valid <= accept;
      if (accept) begin
        o_data <= sel_data;
        o_last <= sel_last;
        o_idx  <= acc_idx;
      end
    end
  end

endmodule
